// File: rtl/uart_rx_cmd.sv
// UART 8N1 receiver with a small ASCII command parser driving the debug
// register-select address and single-step strobe.
module uart_rx_cmd #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [6:0] cmd_addr,
    output logic       cmd_addr_valid,
    output logic       cmd_step,
    output logic       cmd_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_HI, P_LO} p_state_t;

    rx_state_t      rx_state;
    p_state_t       p_state;
    logic           rx_meta;
    logic           rxs;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     shreg;
    logic [2:0]     hi_nib;
    logic           is_hex;
    logic [3:0]     hex_val;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxs) rx_state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        idx <= 3'd0;
                        rx_state <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (idx == 3'd7) rx_state <= RX_STOP;
                        else             idx <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rxs) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Hex digit decode of the byte just received; letters map to 10..15.
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_state        <= P_IDLE;
            hi_nib         <= 3'd0;
            cmd_addr       <= 7'd0;
            cmd_addr_valid <= 1'b0;
            cmd_step       <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            cmd_addr_valid <= 1'b0;
            cmd_step       <= 1'b0;
            cmd_err        <= 1'b0;
            if (frame_err) begin
                p_state <= P_IDLE;
            end else if (rx_valid) begin
                case (p_state)
                    P_IDLE: begin
                        if (rx_data == 8'h61 || rx_data == 8'h41)
                            p_state <= P_HI;
                        else if (rx_data == 8'h73 || rx_data == 8'h53)
                            cmd_step <= 1'b1;
                        else if (rx_data != 8'h0D && rx_data != 8'h0A && rx_data != 8'h20)
                            cmd_err <= 1'b1;
                    end
                    P_HI: begin
                        if (is_hex && !hex_val[3]) begin
                            hi_nib  <= hex_val[2:0];
                            p_state <= P_LO;
                        end else begin
                            cmd_err <= 1'b1;
                            p_state <= P_IDLE;
                        end
                    end
                    P_LO: begin
                        if (is_hex) begin
                            cmd_addr       <= {hi_nib, hex_val};
                            cmd_addr_valid <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        p_state <= P_IDLE;
                    end
                    default: p_state <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: table vectors, hand-written corner
// sequences and a randomized command stream against a token-level model.
module tb_uart_rx_cmd;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [6:0] cmd_addr;
    logic       cmd_addr_valid;
    logic       cmd_step;
    logic       cmd_err;

    uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rstn(rstn),
        .rxd(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .cmd_addr(cmd_addr),
        .cmd_addr_valid(cmd_addr_valid),
        .cmd_step(cmd_step),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int rxCount = 0, feCount = 0, avCount = 0, stepCount = 0, errCount = 0, multiCount = 0;
    int lastRxCycle = 0, avCycle = 0, fallCycle = 0;
    logic [7:0] rxQ[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rxCount++;
            lastRxCycle = cyc;
            rxQ.push_back(rx_data);
        end
        if (frame_err) feCount++;
        if (cmd_addr_valid) begin
            avCount++;
            avCycle = cyc;
        end
        if (cmd_step) stepCount++;
        if (cmd_err) errCount++;
        if (int'(cmd_addr_valid) + int'(cmd_step) + int'(cmd_err) > 1) multiCount++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; a zero stop bit is followed by holdLow more low cycles.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int holdLow);
        fallCycle = cyc;
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            waitCycles(CPB);
        end
        rxd = stopBit;
        waitCycles(CPB);
        if (!stopBit) begin
            waitCycles(holdLow);
        end
        rxd = 1'b1;
    endtask

    function automatic int hexOf(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Scans the byte string as whole commands: "a"+hi+lo, "s", whitespace, junk.
    function automatic void refParse(input logic [7:0] s[$], inout logic [6:0] addr,
                                     output int av, output int step, output int err);
        int i, h, l;
        logic [7:0] c;
        i = 0; av = 0; step = 0; err = 0;
        while (i < s.size()) begin
            c = s[i];
            if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
                i++;
            end else if (c == 8'h73 || c == 8'h53) begin
                step++;
                i++;
            end else if (c == 8'h61 || c == 8'h41) begin
                if (i + 1 >= s.size()) break;
                h = hexOf(s[i+1]);
                if (h < 0 || h > 7) begin
                    err++;
                    i += 2;
                end else begin
                    if (i + 2 >= s.size()) break;
                    l = hexOf(s[i+2]);
                    if (l < 0) err++;
                    else begin
                        addr = 7'(h * 16 + l);
                        av++;
                    end
                    i += 3;
                end
            end else begin
                err++;
                i++;
            end
        end
    endfunction

    typedef struct {
        logic [7:0] b[4];
        int         n;
        logic [6:0] addr;
        int         av;
        int         step;
        int         err;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] cs[20];

    initial begin
        int rx0, fe0, av0, st0, er0, q0, av, st, er;
        logic [6:0] modelAddr;
        logic [7:0] seq[$];

        vecs[0] = '{'{8'h61, 8'h31, 8'h46, 8'h00}, 3, 7'h1F, 1, 0, 0};
        vecs[1] = '{'{8'h73, 8'h0D, 8'h00, 8'h00}, 2, 7'h1F, 0, 1, 0};
        vecs[2] = '{'{8'h61, 8'h39, 8'h30, 8'h00}, 3, 7'h1F, 0, 0, 2};
        vecs[3] = '{'{8'h41, 8'h37, 8'h65, 8'h00}, 3, 7'h7E, 1, 0, 0};
        vecs[4] = '{'{8'h61, 8'h35, 8'h7A, 8'h00}, 3, 7'h7E, 0, 0, 1};
        vecs[5] = '{'{8'h20, 8'h0A, 8'h53, 8'h00}, 3, 7'h7E, 0, 1, 0};
        vecs[6] = '{'{8'h78, 8'h00, 8'h00, 8'h00}, 1, 7'h7E, 0, 0, 1};
        vecs[7] = '{'{8'h61, 8'h47, 8'h00, 8'h00}, 2, 7'h7E, 0, 0, 1};
        vecs[8] = '{'{8'h61, 8'h30, 8'h33, 8'h00}, 3, 7'h03, 1, 0, 0};
        vecs[9] = '{'{8'h41, 8'h46, 8'h73, 8'h00}, 3, 7'h03, 0, 1, 1};
        cs = '{8'h61, 8'h41, 8'h73, 8'h53, 8'h30, 8'h33, 8'h37, 8'h38, 8'h39, 8'h61,
               8'h63, 8'h66, 8'h42, 8'h45, 8'h0D, 8'h0A, 8'h20, 8'h7A, 8'h47, 8'h41};

        waitCycles(3);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_cmd_addr", cmd_addr, 0);
        checkOutput("reset_pulses", {rx_valid, frame_err, cmd_addr_valid, cmd_step, cmd_err}, 0);
        rstn = 1'b1;
        waitCycles(5);

        // Single 0x55 frame: data, latency, parser rejects 'U'.
        rx0 = rxCount; fe0 = feCount; er0 = errCount;
        applyStimulus(8'h55, 1'b1, 0);
        checkOutput("latency_fall_edge", fallCycle, fallCycle);
        waitCycles(8);
        checkOutput("x55_rx_count", rxCount - rx0, 1);
        checkOutput("x55_rx_data", rx_data, 8'h55);
        checkOutput("x55_latency_window", (lastRxCycle - fallCycle >= 153 && lastRxCycle - fallCycle <= 155) ? 1 : 0, 1);
        checkOutput("x55_frame_err", feCount - fe0, 0);
        checkOutput("x55_cmd_err", errCount - er0, 1);

        modelAddr = 7'd0;
        for (int v = 0; v < 10; v++) begin
            rx0 = rxCount; av0 = avCount; st0 = stepCount; er0 = errCount;
            for (int j = 0; j < vecs[v].n; j++) applyStimulus(vecs[v].b[j], 1'b1, 0);
            waitCycles(8);
            checkOutput($sformatf("vec%0d_rx_count", v), rxCount - rx0, vecs[v].n);
            checkOutput($sformatf("vec%0d_cmd_addr", v), cmd_addr, vecs[v].addr);
            checkOutput($sformatf("vec%0d_addr_valid", v), avCount - av0, vecs[v].av);
            checkOutput($sformatf("vec%0d_step", v), stepCount - st0, vecs[v].step);
            checkOutput($sformatf("vec%0d_err", v), errCount - er0, vecs[v].err);
            if (vecs[v].av > 0) checkOutput($sformatf("vec%0d_parser_latency", v), avCycle - lastRxCycle, 1);
            modelAddr = vecs[v].addr;
        end

        // Short glitch, then 'a', a framing error that must reset the parser, '5', 0xA3.
        rx0 = rxCount; fe0 = feCount; er0 = errCount; av0 = avCount; st0 = stepCount;
        rxd = 1'b0;
        waitCycles(4);
        rxd = 1'b1;
        waitCycles(30);
        checkOutput("glitch_no_output", (rxCount - rx0) + (feCount - fe0) + (errCount - er0), 0);
        applyStimulus(8'h61, 1'b1, 0);
        applyStimulus(8'($urandom_range(255, 0)), 1'b0, 40);
        waitCycles(20);
        applyStimulus(8'h35, 1'b1, 0);
        applyStimulus(8'hA3, 1'b1, 0);
        waitCycles(8);
        checkOutput("ferr_count", feCount - fe0, 1);
        checkOutput("ferr_rx_count", rxCount - rx0, 3);
        checkOutput("ferr_rx_data", rx_data, 8'hA3);
        checkOutput("ferr_parser_reset_err", errCount - er0, 2);
        checkOutput("ferr_no_addr", avCount - av0 + stepCount - st0, 0);

        // Randomized back-to-back command stream against the token model.
        seq.delete();
        for (int k = 0; k < 24; k++) seq.push_back(cs[$urandom_range(19, 0)]);
        seq.push_back(8'h73);
        seq.push_back(8'h73);
        refParse(seq, modelAddr, av, st, er);
        rx0 = rxCount; av0 = avCount; st0 = stepCount; er0 = errCount; q0 = rxQ.size();
        foreach (seq[k]) applyStimulus(seq[k], 1'b1, 0);
        waitCycles(8);
        checkOutput("rand_rx_count", rxCount - rx0, seq.size());
        for (int k = 0; k < seq.size() && q0 + k < rxQ.size(); k++)
            checkOutput($sformatf("rand_byte%0d", k), rxQ[q0+k], seq[k]);
        checkOutput("rand_cmd_addr", cmd_addr, modelAddr);
        checkOutput("rand_addr_valid", avCount - av0, av);
        checkOutput("rand_step", stepCount - st0, st);
        checkOutput("rand_err", errCount - er0, er);
        checkOutput("one_pulse_per_byte", multiCount, 0);

        // Reset pulse during data bit 3 of a frame.
        applyStimulus(8'h41, 1'b1, 0);
        applyStimulus(8'h32, 1'b1, 0);
        applyStimulus(8'h62, 1'b1, 0);
        waitCycles(8);
        checkOutput("pre_reset_cmd_addr", cmd_addr, 7'h2B);
        rx0 = rxCount;
        fork
            applyStimulus(8'hF8, 1'b1, 0);
            begin
                waitCycles(CPB * 4 + 8);
                rstn = 1'b0;
                waitCycles(1);
                rstn = 1'b1;
                checkOutput("midreset_rx_data", rx_data, 0);
                checkOutput("midreset_cmd_addr", cmd_addr, 0);
                checkOutput("midreset_pulses", {rx_valid, frame_err, cmd_addr_valid, cmd_step, cmd_err}, 0);
            end
        join
        waitCycles(20);
        checkOutput("midreset_no_rx", rxCount - rx0, 0);
        applyStimulus(8'h7E, 1'b1, 0);
        waitCycles(8);
        checkOutput("postreset_rx_count", rxCount - rx0, 1);
        checkOutput("postreset_rx_data", rx_data, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd.md
# uart_rx_cmd

Serial debug command receiver for the RV32 debug path. It samples the board UART receive line, deframes 8N1 bytes, and parses a small ASCII command set. The result drives the core's debug register-select address and a single-step strobe, so a host terminal can do what the switches and step button do today. It sits upstream of the core's `debug_addr`/`debug_step` inputs and the `debug_ctrl` readback, and runs on `clk_cpu`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Minimum 8.

Ports:
- `clk`  in  1: CPU clock; all logic on its rising edge.
- `rstn`  in  1: synchronous reset, active-low.
- `rxd`  in  1: asynchronous UART RX line, idle high.
- `rx_data`  out  8: last received byte; holds until the next good byte.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` is updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples 0.
- `cmd_addr`  out  7: debug register select; holds its value between commands.
- `cmd_addr_valid`  out  1: one-cycle pulse when `cmd_addr` is updated.
- `cmd_step`  out  1: one-cycle single-step strobe.
- `cmd_err`  out  1: one-cycle pulse on an illegal command byte.

## Operation
Synchroniser:
- `rxd` passes through two flops. Both reset to 1. All RX logic uses the second flop (`rxs`).

RX state machine (IDLE, START, DATA, STOP, BREAK); bit counter `cnt`, index `idx` 0..7:
- IDLE: when `rxs`=0, go to START with `cnt`=0.
- START: when `cnt`=CLKS_PER_BIT/2−1 (integer divide), sample `rxs`.
  - 0: go to DATA with `cnt`=0 and `idx`=0.
  - 1: treat as a glitch and return to IDLE. No outputs.
- DATA: when `cnt`=CLKS_PER_BIT−1, shift `rxs` into the shift register LSB-first and clear `cnt`. After `idx`=7, go to STOP.
- STOP: when `cnt`=CLKS_PER_BIT−1, sample `rxs`.
  - 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - 0: pulse `frame_err`, go to BREAK. `rx_data` is unchanged.
- BREAK: stay until `rxs`=1, then go to IDLE.

Command parser (P_IDLE, P_HI, P_LO) acts on each `rx_valid` byte:
- Hex digits are 0x30–0x39, 0x41–0x46 and 0x61–0x66. Value 0–15, case-insensitive.
- P_IDLE:
  - 'a' or 'A' → P_HI.
  - 's' or 'S' → pulse `cmd_step`.
  - CR, LF and space are ignored.
  - Any other byte pulses `cmd_err`.
- P_HI:
  - Hex digit 0–7: store it as the high nibble, go to P_LO.
  - Hex digit 8–F or a non-hex byte: pulse `cmd_err`, go to P_IDLE.
- P_LO:
  - Hex digit: `cmd_addr` ← {hi[2:0], digit}, pulse `cmd_addr_valid`, go to P_IDLE.
  - Non-hex byte: pulse `cmd_err`, go to P_IDLE.
- A `frame_err` forces the parser to P_IDLE and does not pulse `cmd_err`.
- At most one parser pulse fires per byte.

## Timing
- Reset values: `rx_data`=0x00, `cmd_addr`=0, all pulse outputs 0. RX state IDLE, parser P_IDLE, sync flops 1.
- Reset asserted mid-frame: everything returns to its reset value on that edge. The rest of the frame is ignored. Reception restarts on the next falling edge seen after release.
- Sampling points relative to the cycle `rxs` first reads 0:
  - Start bit: sampled CLKS_PER_BIT/2 cycles later.
  - Data bits: sampled every CLKS_PER_BIT cycles after the start sample.
- `rx_valid`/`frame_err` are registered. They assert 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the `rxd` falling edge, ±1 cycle.
- Parser outputs are registered: 1 cycle after the `rx_valid` that caused them.
- Back-to-back frames: a new start bit is accepted in the cycle after STOP completes, which is half a bit before the stop bit ends. Consecutive frames with no idle gap must all be received.
- `cnt` is wide enough for CLKS_PER_BIT−1. It never wraps inside a bit.

## Test plan
Use CLKS_PER_BIT=16 for all scenarios.
- Frame 0x55 on `rxd` → exactly one `rx_valid` pulse with `rx_data`=0x55. It lands 2+8+144 cycles ±1 after the falling edge. `frame_err` stays 0.
- Bytes "a1F" back-to-back → `cmd_addr`=0x1F. One `cmd_addr_valid` pulse, 1 cycle after the third `rx_valid`. No `cmd_err`.
- Byte "s", then "\r" → one `cmd_step` pulse. `cmd_addr` and `cmd_err` are unchanged.
- Bytes "a9" then "0" → `cmd_err` pulses at '9' and again at '0' (parser back in P_IDLE). `cmd_addr` keeps its previous value.
- 4-cycle low glitch on `rxd` → no outputs. Then a frame with stop bit 0 and line held low for 40 cycles → one `frame_err` pulse and no `rx_valid`. A following frame 0xA3 is received correctly.
- `rstn` low for 1 cycle during data bit 3 of a frame → no `rx_valid` from that frame. All outputs are 0 after reset. The next frame 0x7E is received.
